ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Receives PS/2 keyboard frames, decodes Scan Code Set 2 make/break sequences, and presents the ASCII value of the key currently held. It sits between the board PS2_CLK/PS2_DAT pins and the game logic. The game logic compares `ascii` against falling characters, against Enter (8'd13) to change screens, and against the release code to re-arm removal.

## Interface
- `TIMEOUT_CYCLES`, default 50000: clk cycles without a ps2_clk falling edge after which a partial frame is discarded (1 ms at 50 MHz).
- `RELEASE_CODE`, default 8'h31: value driven on `ascii` at reset and after the held key is released.
- `clk`  in  1  system clock, 50 MHz (CLOCK_50).
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to clk.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to clk.
- `ascii`  out  8  ASCII of the held key, or RELEASE_CODE when no key is held.
- `key_valid`  out  1  one-cycle pulse when `ascii` is loaded from a make code.

## Operation
- ps2_clk and ps2_data each pass through a 3-flop synchronizer. A falling edge is detected when sync stage 2 is 0 and stage 3 is 1.
- Frame format, sampled on each falling edge: start 0, 8 data bits LSB first, odd parity, stop 1.
- The frame is accepted when the start bit is 0 and the stop bit is 1. Otherwise the byte is dropped silently.
- Decode FSM states:
  - IDLE: F0 → BREAK; E0 → EXT; any other byte → make.
  - BREAK: the next byte is a break for that code; return to IDLE.
  - EXT: the next byte is ignored (E0 xx); return to IDLE. If that byte is F0, go to EXT_BREAK.
  - EXT_BREAK: the next byte is ignored; return to IDLE.
- Make of a mapped code:
  - `ascii` ← mapped value, `held` ← scan code, pulse `key_valid`.
  - Typematic repeats of the same code re-pulse `key_valid`.
- Make of an unmapped code: no change, no pulse.
- Break of a code equal to `held`: `ascii` ← RELEASE_CODE, `held` cleared. Break of any other code: no change.
- Mapping, lowercase:
  - 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A → 'a'..'z'.
  - 45 16 1E 26 25 2E 36 3D 3E 46 → '0'..'9'.
  - 5A → 8'h0D; 29 → 8'h20.
- Make of '1' and release both yield 8'h31 by design; consumers distinguish them by `key_valid`.

## Timing
- Reset values: `ascii` = RELEASE_CODE, `key_valid` = 0, FSM = IDLE, bit counter = 0, `held` = 0.
- Latency: `ascii` and `key_valid` update on the 2nd clk edge after the synchronized falling edge carrying the stop bit.
  - Edge 1: byte complete.
  - Edge 2: decode register update.
- Timeout: if the bit counter is non-zero and TIMEOUT_CYCLES elapse with no falling edge, the counter resets to 0. The decode FSM state is kept.
- Reset mid-frame discards the partial frame. `ascii` returns to RELEASE_CODE immediately (asynchronously).
- `key_valid` is never high on two consecutive cycles.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: a frame whose 9 bits (data + parity) do not have odd parity is dropped.
  - Undefined: the parity bit is sampled but ignored.

## Structure
- Package `ps2_pkg` holds:
  - scan-code constants `SC_BREAK` = 8'hF0, `SC_EXT` = 8'hE0, `SC_ENTER` = 8'h5A;
  - the decode-state enum;
  - the scancode→ASCII function.
- Sub-module `ps2_rx`: synchronizer, edge detect, bit shifting, timeout, and parity. It outputs `byte_data[7:0]` plus a one-cycle `byte_strobe`.
- The top contains the decode FSM and the output registers.

## Test plan
- Send frame 0x1C → `ascii` = 8'h61, one `key_valid` pulse, 2 cycles after the stop edge.
- Send 1C, then F0 1C → `ascii` = 8'h31, no pulse on the break.
- Send 5A, then F0 1C (different key) → `ascii` stays 8'h0D.
- Send E0 75, then E0 F0 75 → `ascii` unchanged, no pulses.
- With PS2_PARITY_CHECK_EN: frame 0x1C with even parity → no change. Without the macro → `ascii` = 8'h61.
- Send 4 bits, idle 60000 cycles, then full frame 0x16 → `ascii` = 8'h31 with a `key_valid` pulse. Assert `rst_n` mid-frame → `ascii` = 8'h31 at once.

Source files
------------

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Scan Code Set 2 constants, decode-state enum, scancode->ASCII map
// Revision : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } decode_state_t;

    // Bit 8 flags a mapped code; bits 7:0 carry the lowercase ASCII value.
    function automatic logic [8:0] scan_to_ascii(input logic [7:0] code);
        logic [8:0] map;
        map = 9'h000;
        case (code)
            8'h1C: map = {1'b1, 8'h61};
            8'h32: map = {1'b1, 8'h62};
            8'h21: map = {1'b1, 8'h63};
            8'h23: map = {1'b1, 8'h64};
            8'h24: map = {1'b1, 8'h65};
            8'h2B: map = {1'b1, 8'h66};
            8'h34: map = {1'b1, 8'h67};
            8'h33: map = {1'b1, 8'h68};
            8'h43: map = {1'b1, 8'h69};
            8'h3B: map = {1'b1, 8'h6A};
            8'h42: map = {1'b1, 8'h6B};
            8'h4B: map = {1'b1, 8'h6C};
            8'h3A: map = {1'b1, 8'h6D};
            8'h31: map = {1'b1, 8'h6E};
            8'h44: map = {1'b1, 8'h6F};
            8'h4D: map = {1'b1, 8'h70};
            8'h15: map = {1'b1, 8'h71};
            8'h2D: map = {1'b1, 8'h72};
            8'h1B: map = {1'b1, 8'h73};
            8'h2C: map = {1'b1, 8'h74};
            8'h3C: map = {1'b1, 8'h75};
            8'h2A: map = {1'b1, 8'h76};
            8'h1D: map = {1'b1, 8'h77};
            8'h22: map = {1'b1, 8'h78};
            8'h35: map = {1'b1, 8'h79};
            8'h1A: map = {1'b1, 8'h7A};
            8'h45: map = {1'b1, 8'h30};
            8'h16: map = {1'b1, 8'h31};
            8'h1E: map = {1'b1, 8'h32};
            8'h26: map = {1'b1, 8'h33};
            8'h25: map = {1'b1, 8'h34};
            8'h2E: map = {1'b1, 8'h35};
            8'h36: map = {1'b1, 8'h36};
            8'h3D: map = {1'b1, 8'h37};
            8'h3E: map = {1'b1, 8'h38};
            8'h46: map = {1'b1, 8'h39};
            SC_ENTER: map = {1'b1, 8'h0D};
            8'h29: map = {1'b1, 8'h20};
            default: map = 9'h000;
        endcase
        return map;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_decoder_rx.sv
// ============================================================================
// Module   : ps2_rx
// Purpose  : PS/2 frame receiver; PS2_PARITY_CHECK_EN drops odd-parity errors
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_strobe
);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit c_parity_en = 1'b1;
`else
    localparam bit c_parity_en = 1'b0;
`endif
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]         r_clk_sync;
    logic [2:0]         r_dat_sync;
    logic [3:0]         r_bit_cnt;
    logic [9:0]         r_shift;
    logic [c_cnt_w-1:0] r_idle_cnt;
    logic               w_fall;
    logic [10:0]        w_frame;
    logic               w_frame_ok;

    assign w_fall     = !r_clk_sync[1] && r_clk_sync[2];
    // Stop bit joins the ten bits already shifted in; bit 0 is the start bit.
    assign w_frame    = {r_dat_sync[1], r_shift};
    assign w_frame_ok = !w_frame[0] && w_frame[10] && ((^w_frame[9:1]) || !c_parity_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= 3'b111;
            r_dat_sync  <= 3'b111;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 10'd0;
            r_idle_cnt  <= '0;
            byte_data   <= 8'd0;
            byte_strobe <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync  <= {r_dat_sync[1:0], ps2_data};
            byte_strobe <= 1'b0;
            if (w_fall) begin
                r_idle_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt   <= 4'd0;
                    byte_data   <= w_frame[8:1];
                    byte_strobe <= w_frame_ok;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_shift   <= {r_dat_sync[1], r_shift[9:1]};
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_idle_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1)) begin
                    r_bit_cnt  <= 4'd0;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + c_cnt_w'(1);
                end
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : Scan Code Set 2 make/break decoder presenting held-key ASCII
//            (optional PS2_PARITY_CHECK_EN enables parity rejection in ps2_rx)
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] RELEASE_CODE   = 8'h31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic       key_valid
);

    logic [7:0]    w_byte;
    logic          w_strobe;
    logic [8:0]    w_map;
    decode_state_t r_state, w_state_nxt;
    logic [7:0]    r_ascii, w_ascii_nxt;
    logic [7:0]    r_held, w_held_nxt;
    logic          r_key_valid, w_key_valid_nxt;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_data  (w_byte),
        .byte_strobe(w_strobe)
    );

    assign w_map = scan_to_ascii(w_byte);

    always_comb begin
        w_state_nxt     = r_state;
        w_ascii_nxt     = r_ascii;
        w_held_nxt      = r_held;
        w_key_valid_nxt = 1'b0;
        if (w_strobe) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_byte == SC_BREAK) begin
                        w_state_nxt = ST_BREAK;
                    end else if (w_byte == SC_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else if (w_map[8]) begin
                        w_ascii_nxt     = w_map[7:0];
                        w_held_nxt      = w_byte;
                        w_key_valid_nxt = 1'b1;
                    end
                end
                ST_BREAK: begin
                    w_state_nxt = ST_IDLE;
                    if (w_byte == r_held) begin
                        w_ascii_nxt = RELEASE_CODE;
                        w_held_nxt  = 8'd0;
                    end
                end
                // Extended keys are not mapped, so their makes and breaks are swallowed.
                ST_EXT:       w_state_nxt = (w_byte == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
                ST_EXT_BREAK: w_state_nxt = ST_IDLE;
                default:      w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ascii     <= RELEASE_CODE;
            r_held      <= 8'd0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ascii     <= w_ascii_nxt;
            r_held      <= w_held_nxt;
            r_key_valid <= w_key_valid_nxt;
        end
    end

    assign ascii     = r_ascii;
    assign key_valid = r_key_valid;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// ============================================================================
// Module   : tb_ps2_key_decoder
// Purpose  : Self-checking bench for ps2_key_decoder against a byte-sequence model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_key_decoder;

    localparam int         HALF = 12;
    localparam logic [7:0] REL  = 8'h31;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ascii;
    logic       key_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_ascii;
    logic [7:0] m_held;
    logic [7:0] m_seq[$];
    bit         m_par_en;

    logic [7:0] t_letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                  8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                  8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                  8'h35, 8'h1A};
    logic [7:0] t_digits[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46};

    always #10 clk = ~clk;

    ps2_key_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ascii    (ascii),
        .key_valid(key_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_map(input logic [7:0] b);
        for (int i = 0; i < 26; i++) if (t_letters[i] == b) return 8'h61 + i;
        for (int i = 0; i < 10; i++) if (t_digits[i] == b) return 8'h30 + i;
        if (b == 8'h5A) return 8'h0D;
        if (b == 8'h29) return 8'h20;
        return -1;
    endfunction

    // Bytes are gathered into sequences [x], [F0 x], [E0 x], [E0 F0 x];
    // the whole sequence is interpreted once its final byte arrives.
    function automatic bit model_byte(input logic [7:0] b);
        int a;
        bit pulse;
        pulse = 1'b0;
        if ((m_seq.size() == 0 && (b == 8'hF0 || b == 8'hE0)) ||
            (m_seq.size() == 1 && m_seq[0] == 8'hE0 && b == 8'hF0)) begin
            m_seq.push_back(b);
            return 1'b0;
        end
        if (m_seq.size() == 0) begin
            a = model_map(b);
            if (a >= 0) begin
                m_ascii = a[7:0];
                m_held  = b;
                pulse   = 1'b1;
            end
        end else if (m_seq[0] == 8'hF0) begin
            if (b == m_held) begin
                m_ascii = REL;
                m_held  = 8'h00;
            end
        end
        m_seq.delete();
        return pulse;
    endfunction

    // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
    task automatic send_frame(input logic [7:0] b, input int kind);
        logic [10:0] f;
        bit          accept;
        bit          pulse;
        int          first;
        int          cnt;
        f = {1'b1, ~^b, b, 1'b0};
        if (kind == 1) f[9]  = ~f[9];
        if (kind == 2) f[10] = 1'b0;
        if (kind == 3) f[0]  = 1'b1;
        accept = (kind == 0) || (kind == 1 && !m_par_en);
        pulse  = accept ? model_byte(b) : 1'b0;
        first  = 0;
        cnt    = 0;
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            first = 0;
            cnt   = 0;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (key_valid) begin
                    cnt++;
                    if (first == 0) first = k;
                end
            end
            ps2_clk = 1'b1;
        end
        check("kv_latency", first, pulse ? 4 : 0);
        check("kv_count", cnt, pulse ? 1 : 0);
        check("ascii", ascii, m_ascii);
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = $urandom_range(0, 1);
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [7:0] pick_mapped();
        int r;
        r = $urandom_range(0, 37);
        if (r < 26) return t_letters[r];
        if (r < 36) return t_digits[r - 26];
        return (r == 36) ? 8'h5A : 8'h29;
    endfunction

    initial begin
`ifdef PS2_PARITY_CHECK_EN
        m_par_en = 1'b1;
`else
        m_par_en = 1'b0;
`endif
        m_ascii = REL;
        m_held  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ascii", ascii, REL);
        check("rst_key_valid", key_valid, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_frame(8'h1C, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        send_frame(8'h5A, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        send_frame(8'hE0, 0);
        send_frame(8'h75, 0);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
        send_frame(8'h1C, 1);

        send_bits(4);
        repeat (60000) @(negedge clk);
        send_frame(8'h16, 0);

        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4)       send_frame(pick_mapped(), 0);
            else if (r == 5)  send_frame(8'hF0, 0);
            else if (r == 6)  send_frame(8'hE0, 0);
            else if (r == 7)  send_frame(8'($urandom), 0);
            else if (r == 8) begin
                send_frame(8'hF0, 0);
                send_frame((m_held == 8'h00) ? 8'h1C : m_held, 0);
            end else          send_frame(pick_mapped(), $urandom_range(1, 3));
        end

        send_frame(8'h1C, 0);
        send_bits(5);
        rst_n = 1'b0;
        #1;
        check("rst_async_ascii", ascii, REL);
        m_ascii = REL;
        m_held  = 8'h00;
        m_seq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h29, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
